// File: rtl/serial_word_receiver_if.sv
// Serial bit stream in, parallel word out with valid/ready, plus sticky status.
// master drives the serial side and QReady/ClearErr; slave is the receiver.
interface serial_word_receiver_if #(parameter int WIDTH = 4);
    logic             SerIn;
    logic             SerValid;
    logic             Dir;
    logic             Flush;
    logic             QReady;
    logic             ClearErr;
    logic [WIDTH-1:0] Q;
    logic             QValid;
    logic             Busy;
    logic             Overrun;
    logic             ParityErr;

    modport master (
        output SerIn, SerValid, Dir, Flush, QReady, ClearErr,
        input  Q, QValid, Busy, Overrun, ParityErr
    );

    modport slave (
        input  SerIn, SerValid, Dir, Flush, QReady, ClearErr,
        output Q, QValid, Busy, Overrun, ParityErr
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver, LSB- or MSB-first, registered Q under valid/ready.
// Latency: Q/QValid update on the edge sampling the last bit; a full Q stalls nothing, it drops and flags Overrun.
// Optional trailing even-parity bit per word: define SER_RX_PARITY_EN.
module serial_word_receiver #(
    parameter int WIDTH = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    serial_word_receiver_if.slave bus
);
`ifdef SER_RX_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             order_q, order_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qvld_q, qvld_d;
    logic             ovr_q, ovr_d;
    logic             order_now, take, last, data_bit, deliver;
    logic [WIDTH-1:0] sr_next, word;
`ifdef SER_RX_PARITY_EN
    logic             par_q, par_d, par_next;
    logic             perr_q, perr_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        order_d   = order_q;
        sr_d      = sr_q;
        q_d       = q_q;
        qvld_d    = qvld_q;
        ovr_d     = ovr_q & ~bus.ClearErr;
        take      = bus.SerValid & ~bus.Flush;
        last      = take && (cnt_q == LAST);
        order_now = (state_q == IDLE) ? bus.Dir : order_q;
        // MSB-first shifts toward the MSB; LSB-first enters at the MSB and walks down
        sr_next   = order_now ? {sr_q[WIDTH-2:0], bus.SerIn} : {bus.SerIn, sr_q[WIDTH-1:1]};
`ifdef SER_RX_PARITY_EN
        par_d     = par_q;
        par_next  = (state_q == IDLE) ? bus.SerIn : (par_q ^ bus.SerIn);
        data_bit  = (cnt_q != CW'(WIDTH));
        word      = sr_q;
`else
        data_bit  = 1'b1;
        word      = sr_next;
`endif
        deliver   = last && (!qvld_q || bus.QReady);

        if (bus.Flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bus.SerValid) begin
            if (state_q == IDLE) order_d = bus.Dir;
            if (data_bit) sr_d = sr_next;
`ifdef SER_RX_PARITY_EN
            par_d = par_next;
`endif
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = SHIFT;
                cnt_d   = cnt_q + CW'(1);
            end
        end

        if (qvld_q && bus.QReady) qvld_d = 1'b0;
        if (deliver) begin
            q_d    = word;
            qvld_d = 1'b1;
        end else if (last) begin
            ovr_d = 1'b1;
        end
`ifdef SER_RX_PARITY_EN
        perr_d = (perr_q & ~bus.ClearErr) | (deliver & par_next);
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            order_q <= 1'b0;
            sr_q    <= '0;
            q_q     <= '0;
            qvld_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SER_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            qvld_q  <= qvld_d;
            ovr_q   <= ovr_d;
`ifdef SER_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.Q       = q_q;
    assign bus.QValid  = qvld_q;
    assign bus.Busy    = (state_q == SHIFT);
    assign bus.Overrun = ovr_q;
`ifdef SER_RX_PARITY_EN
    assign bus.ParityErr = perr_q;
`else
    assign bus.ParityErr = 1'b0;
`endif
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver, WIDTH=4; parity steps follow SER_RX_PARITY_EN.
module tb_serial_word_receiver;
    logic Clock = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    serial_word_receiver_if #(.WIDTH(4)) bus ();
    serial_word_receiver #(.WIDTH(4)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.SerIn    = b;
        bus.SerValid = 1'b1;
        tick();
        bus.SerValid = 1'b0;
    endtask

    // seq[0] is the first bit on the wire; every bit except the final one of the frame
    task automatic send_pre(input logic [3:0] seq);
        send_bit(seq[0]);
        send_bit(seq[1]);
        send_bit(seq[2]);
`ifdef SER_RX_PARITY_EN
        send_bit(seq[3]);
`endif
    endtask

    task automatic send_last(input logic [3:0] seq, input logic bad);
`ifdef SER_RX_PARITY_EN
        send_bit((^seq) ^ bad);
`else
        send_bit(seq[3] ^ bad);
`endif
    endtask

    task automatic send_word(input logic [3:0] seq);
        send_pre(seq);
        send_last(seq, 1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        bus.SerIn = 0; bus.SerValid = 0; bus.Dir = 0;
        bus.Flush = 0; bus.QReady = 0; bus.ClearErr = 0;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_q", bus.Q, 4'h0);
        chk("rst_qvalid", bus.QValid, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_overrun", bus.Overrun, 0);
        chk("rst_parityerr", bus.ParityErr, 0);

        // LSB-first 1,0,1,1
        bus.QReady = 1; bus.Dir = 0;
        send_bit(1); chk("lsb_busy1", bus.Busy, 1);
        send_bit(0); chk("lsb_busy2", bus.Busy, 1);
        send_bit(1); chk("lsb_busy3", bus.Busy, 1);
`ifdef SER_RX_PARITY_EN
        send_bit(1);
        send_bit(1);
`else
        send_bit(1);
`endif
        chk("lsb_q", bus.Q, 4'b1101);
        chk("lsb_qvalid", bus.QValid, 1);
        chk("lsb_busy_done", bus.Busy, 0);
        tick();
        chk("lsb_qvalid_drop", bus.QValid, 0);
        chk("lsb_q_hold", bus.Q, 4'b1101);

        // MSB-first 1,0,1,1, then again with Dir toggled after the first bit
        bus.Dir = 1;
        send_word(4'b1101);
        chk("msb_q", bus.Q, 4'b1011);
        bus.Dir = 1;
        send_bit(1);
        bus.Dir = 0;
        send_bit(0); send_bit(1);
`ifdef SER_RX_PARITY_EN
        send_bit(1);
`endif
        send_last(4'b1101, 1'b0);
        chk("msb_dirtoggle_q", bus.Q, 4'b1011);
        chk("msb_dirtoggle_qvalid", bus.QValid, 1);

        // Overrun with QReady low
        tick();
        bus.QReady = 0; bus.Dir = 0;
        send_word(4'b0011);
        chk("ovr_first_q", bus.Q, 4'h3);
        send_word(4'b1010);
        chk("ovr_q_kept", bus.Q, 4'h3);
        chk("ovr_flag", bus.Overrun, 1);
        chk("ovr_qvalid", bus.QValid, 1);
        bus.ClearErr = 1; tick(); bus.ClearErr = 0;
        chk("ovr_cleared", bus.Overrun, 0);
        // completion coincides with acceptance
        send_pre(4'b0101);
        bus.QReady = 1;
        send_last(4'b0101, 1'b0);
        chk("accept_same_q", bus.Q, 4'h5);
        chk("accept_same_qvalid", bus.QValid, 1);
        chk("accept_same_ovr", bus.Overrun, 0);
        // overrun on same edge as ClearErr: set wins
        bus.QReady = 0;
        send_pre(4'b1111);
        bus.ClearErr = 1;
        send_last(4'b1111, 1'b0);
        bus.ClearErr = 0;
        chk("clr_vs_set_ovr", bus.Overrun, 1);
        chk("clr_vs_set_q", bus.Q, 4'h5);
        bus.ClearErr = 1; bus.QReady = 1; tick(); bus.ClearErr = 0;
        chk("drain_qvalid", bus.QValid, 0);

        // Flush with SerValid discards partial word and the bit
        send_bit(1); send_bit(1);
        bus.Flush = 1;
        send_bit(1);
        bus.Flush = 0;
        chk("flush_busy", bus.Busy, 0);
        chk("flush_qvalid", bus.QValid, 0);
        send_word(4'b0110);
        chk("flush_next_q", bus.Q, 4'b0110);

        // Reset mid-word with an unconsumed Q
        bus.QReady = 0;
        send_bit(1); send_bit(0);
        Reset = 1; tick(); Reset = 0;
        chk("rst_mid_busy", bus.Busy, 0);
        chk("rst_mid_qvalid", bus.QValid, 0);
        chk("rst_mid_q", bus.Q, 4'h0);
        send_word(4'b1001);
        chk("rst_mid_next_q", bus.Q, 4'b1001);
        chk("rst_mid_ovr", bus.Overrun, 0);

`ifdef SER_RX_PARITY_EN
        bus.QReady = 1; tick();
        send_word(4'b0011);
        chk("par_good_q", bus.Q, 4'b0011);
        chk("par_good_err", bus.ParityErr, 0);
        send_pre(4'b0011);
        send_last(4'b0011, 1'b1);
        chk("par_bad_err", bus.ParityErr, 1);
        chk("par_bad_q", bus.Q, 4'b0011);
        chk("par_bad_qvalid", bus.QValid, 1);
        bus.ClearErr = 1; tick(); bus.ClearErr = 0;
        chk("par_cleared", bus.ParityErr, 0);
`else
        chk("par_tied", bus.ParityErr, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-to-parallel receiver: the capture end of the universal shift register's serial shift path. It accepts one serial bit per qualified clock, assembles WIDTH-bit words in either bit order, and presents each word on a registered parallel output under a valid/ready handshake. Overrun and, optionally, parity errors are flagged as sticky status.

## Interface
- WIDTH, 4, data word width in bits; legal range 2..16.
- Clock  input  1  rising-edge clock.
- Reset  input  1  reset; synchronous, active-high; clears all state on the next rising edge of Clock.
- SerIn  input  1  serial data bit.
- SerValid  input  1  SerIn is valid this cycle; one bit is consumed per cycle with SerValid=1.
- Dir  input  1  bit order: 0 = LSB-first, 1 = MSB-first; sampled on the first bit of each word only.
- Flush  input  1  discards the partial word and returns to IDLE.
- QReady  input  1  downstream accepts Q this cycle.
- ClearErr  input  1  clears the sticky error flags.
- Q  output  WIDTH  received word; bit 0 = LSB, bit WIDTH-1 = MSB.
- QValid  output  1  Q holds an unconsumed word.
- Busy  output  1  a word is partially received.
- Overrun  output  1  sticky: a completed word was dropped.
- ParityErr  output  1  sticky: parity mismatch (see Configuration).

## Operation
- States: IDLE (bit count 0) and SHIFT (1..N-1 bits held), where N = WIDTH, or WIDTH+1 with parity. Busy=1 exactly in SHIFT.
- IDLE + SerValid: latch Dir into an internal order bit, store the first bit, count=1, go to SHIFT. With N=1 impossible (WIDTH>=2).
- SHIFT + SerValid: store the bit, increment count. On the Nth bit: word complete, count=0, go to IDLE.
- LSB-first: the k-th data bit received (k=0 first) lands in Q[k]. MSB-first: the k-th lands in Q[WIDTH-1-k]. Implemented as a shift register shifting toward bit 0 (LSB-first, new bit enters at MSB) or toward MSB (MSB-first, new bit enters at bit 0).
- Dir changes mid-word are ignored until the next word.
- Completion with QValid=0, or with QValid=1 and QReady=1: shift-register contents transfer to Q, QValid=1.
- Completion with QValid=1 and QReady=0: new word dropped, Q unchanged, Overrun set.
- QValid=1, QReady=1 and no completion: QValid falls to 0; Q retains its value.
- Flush: count=0, IDLE; partial word discarded; Q, QValid and flags untouched. Flush and SerValid in the same cycle: Flush wins and the bit is discarded.
- ClearErr clears Overrun and ParityErr. If an error event occurs in the same cycle, the flag is set (set wins).
- Reset mid-word or mid-handshake: all state cleared; the partial word and any unconsumed Q are lost.

## Timing
- Reset values: Q=0, QValid=0, Busy=0, Overrun=0, ParityErr=0, count=0, state IDLE.
- All outputs are registered. There is no combinational path from input to output.
- Latency: the rising edge that samples the Nth bit updates Q and QValid, which are visible in that same following cycle.
- Throughput: one bit per cycle sustained. Back-to-back words need no idle cycle. The first bit of the next word may be sampled on the edge after completion.
- Handshake: a transfer occurs on any edge with QValid=1 and QReady=1. Q is stable while QValid=1 and QReady=0.
- SerValid=0 cycles freeze the count and shift register indefinitely; there is no timeout.

## Configuration
- SER_RX_PARITY_EN defined:
  - Each word is WIDTH data bits followed by one even-parity bit (the XOR of the data bits and the parity bit must be 0).
  - On completion with a mismatch, ParityErr is set. The word is still delivered under the normal Q/Overrun rules.
  - A dropped word is not parity-checked.
- SER_RX_PARITY_EN undefined:
  - N = WIDTH and no parity bit is consumed.
  - ParityErr is tied to 0.

## Test plan
WIDTH=4 and parity disabled unless stated.
- Reset -> Q=0, QValid=0, Busy=0, Overrun=0, ParityErr=0; Reset asserted mid-word (after 2 bits) -> Busy=0 next cycle, and the next 4 bits form a clean word.
- Dir=0, bits 1,0,1,1 on consecutive cycles, QReady=1 -> Q=4'b1101 and QValid=1 for one cycle. Busy is 1 after bits 1..3.
- Dir=1, bits 1,0,1,1 -> Q=4'b1011. Dir toggled after the first bit -> result unchanged.
- QReady=0, two complete words 0x3 then 0xA -> Q stays 0x3 and Overrun=1. ClearErr -> Overrun=0. Completion on the same cycle as QReady=1 -> Q=new word, QValid stays 1, no Overrun.
- Two bits, then Flush together with SerValid -> Busy=0 and the bit is ignored. The following 4 bits 0,1,1,0 (Dir=0) -> Q=4'b0110.
- SER_RX_PARITY_EN defined:
  - bits 1,1,0,0 with parity 0 -> Q=4'b0011, ParityErr=0.
  - same bits with parity 1 -> ParityErr=1 and the word is still delivered.
